// File: rtl/tia_hsync_pkg.sv
// TIA horizontal sync counter: shared state type and LFSR constants.
// Decode states are derived from the feedback rule, not hand-entered.
package tia_hsync_pkg;

    typedef logic [5:0] hstate_t;

    localparam int LINE_COUNTS = 57;

    function automatic hstate_t lfsr_step(hstate_t s);
        return {s[0] ~^ s[1], s[5:1]};
    endfunction

    function automatic hstate_t lfsr_at(int n);
        hstate_t s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    localparam hstate_t LFSR_N0   = lfsr_at(0);
    localparam hstate_t LFSR_SHS  = lfsr_at(4);
    localparam hstate_t LFSR_RHS  = lfsr_at(8);
    localparam hstate_t LFSR_RCB  = lfsr_at(12);
    localparam hstate_t LFSR_RHB  = lfsr_at(16);
    localparam hstate_t LFSR_LRHB = lfsr_at(18);
    localparam hstate_t LFSR_CNT  = lfsr_at(36);
    localparam hstate_t LFSR_END  = lfsr_at(LINE_COUNTS - 1);

endpackage

// File: rtl/tia_hsync_decode.sv
// Horizontal event decoder: one-count strobes from the raw LFSR state.
module tia_hsync_decode
    import tia_hsync_pkg::*;
(
    input  hstate_t lfsr,
    output logic    shs,
    output logic    rhs,
    output logic    rcb,
    output logic    rhb,
    output logic    lrhb,
    output logic    cnt
);

    always_comb begin
        shs  = 1'b0;
        rhs  = 1'b0;
        rcb  = 1'b0;
        rhb  = 1'b0;
        lrhb = 1'b0;
        cnt  = 1'b0;
        unique case (lfsr)
            LFSR_SHS:  shs  = 1'b1;
            LFSR_RHS:  rhs  = 1'b1;
            LFSR_RCB:  rcb  = 1'b1;
            LFSR_RHB:  rhb  = 1'b1;
            LFSR_LRHB: lrhb = 1'b1;
            LFSR_CNT:  cnt  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/tia_hsync_counter.sv
// TIA horizontal timing front end: biphase divider, 57-state
// polynomial line counter, and per-line event strobes.
module tia_hsync_counter
    import tia_hsync_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rsyn,
    output logic       hphi1,
    output logic       hphi2,
    output logic       rsynl,
    output logic [5:0] lfsr_out,
    output logic       shb,
    output logic       rsynd,
    output logic       shs,
    output logic       rhs,
    output logic       rcb,
    output logic       rhb,
    output logic       lrhb,
    output logic       cnt
);

    logic [1:0] phase;
    logic [1:0] phase_nxt;
    logic       reload;

    assign phase_nxt = rsyn ? 2'd0 : phase + 2'd1;
    assign reload    = hphi2 && (lfsr_out == LFSR_END || rsynl);

    // A reload that coincides with rsyn already satisfies it,
    // so no second request is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 2'd0;
            hphi1    <= 1'b0;
            hphi2    <= 1'b0;
            lfsr_out <= LFSR_N0;
            shb      <= 1'b0;
            rsynl    <= 1'b0;
            rsynd    <= 1'b0;
        end else begin
            phase <= phase_nxt;
            hphi1 <= (phase_nxt == 2'd0);
            hphi2 <= (phase_nxt == 2'd2);
            if (hphi2) begin
                lfsr_out <= reload ? LFSR_N0 : lfsr_step(lfsr_out);
                shb      <= reload;
            end
            if (reload) begin
                rsynl <= 1'b0;
            end else if (rsyn) begin
                rsynl <= 1'b1;
            end
            if (hphi1) begin
                rsynd <= rsynl;
            end
        end
    end

    tia_hsync_decode u_decode (
        .lfsr (lfsr_out),
        .shs  (shs),
        .rhs  (rhs),
        .rcb  (rcb),
        .rhb  (rhb),
        .lrhb (lrhb),
        .cnt  (cnt)
    );

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Directed bench for tia_hsync_counter: divider phasing, line
// length, decode windows, RSYNC handling and async reset.
module tb_tia_hsync_counter;

    logic       clk;
    logic       rst_n;
    logic       rsyn;
    logic       hphi1;
    logic       hphi2;
    logic       rsynl;
    logic [5:0] lfsr_out;
    logic       shb;
    logic       rsynd;
    logic       shs;
    logic       rhs;
    logic       rcb;
    logic       rhb;
    logic       lrhb;
    logic       cnt;

    int errors = 0;
    int checks = 0;

    logic [16:0] all_out;
    logic [5:0]  strobes;

    assign all_out = {hphi1, hphi2, rsynl, lfsr_out, shb,
                      rsynd, shs, rhs, rcb, rhb, lrhb, cnt};
    assign strobes = {shs, rhs, rcb, rhb, lrhb, cnt};

    tia_hsync_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsyn     (rsyn),
        .hphi1    (hphi1),
        .hphi2    (hphi2),
        .rsynl    (rsynl),
        .lfsr_out (lfsr_out),
        .shb      (shb),
        .rsynd    (rsynd),
        .shs      (shs),
        .rhs      (rhs),
        .rcb      (rcb),
        .rhb      (rhb),
        .lrhb     (lrhb),
        .cnt      (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one tick after an shb rising edge (n=0, k=0).
    task automatic wait_rise();
        logic prev;
        bit   seen;
        prev = shb;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (shb && !prev) seen = 1;
            prev = shb;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL wait_rise: shb=%b after 300 clk, need a rise", shb);
        end
    endtask

    task automatic check_phases(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            checks++;
            if (hphi1 !== 1'(k % 4 == 0)) begin
                errors++;
                $display("FAIL hphi1 edge %0d: got %b want %b",
                         k, hphi1, (k % 4 == 0));
            end
            checks++;
            if (hphi2 !== 1'(k % 4 == 2)) begin
                errors++;
                $display("FAIL hphi2 edge %0d: got %b want %b",
                         k, hphi2, (k % 4 == 2));
            end
            if (k == 3) begin
                checks++;
                if (lfsr_out !== 6'b100000) begin
                    errors++;
                    $display("FAIL first_shift: lfsr=%b want 100000", lfsr_out);
                end
            end
        end
    endtask

    task automatic test_reset();
        rsyn  = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (all_out !== 17'd0) begin
            errors++;
            $display("FAIL reset_outs: got %h want 0", all_out);
        end
        rst_n = 1'b1;
        check_phases(12);
    endtask

    task automatic test_free_run();
        bit   seen [64];
        int   distinct;
        int   rises;
        int   k;
        int   n;
        bit   synced;
        logic prev;
        logic [5:0] exp_str;
        for (int i = 0; i < 64; i++) seen[i] = 0;
        rises  = 0;
        k      = 0;
        synced = 0;
        prev   = shb;
        for (int c = 0; c < 1000; c++) begin
            tick();
            seen[lfsr_out] = 1;
            if (synced) k++;
            if (shb && !prev) begin
                rises++;
                if (synced) begin
                    checks++;
                    if (k != 228) begin
                        errors++;
                        $display("FAIL line_len: got %0d want 228", k);
                    end
                end
                synced = 1;
                k = 0;
            end
            prev = shb;
            if (synced) begin
                n = k / 4;
                checks++;
                if (shb !== 1'(n == 0)) begin
                    errors++;
                    $display("FAIL shb k=%0d: got %b want %b", k, shb, (n == 0));
                end
                exp_str = {n == 4, n == 8, n == 12, n == 16, n == 18, n == 36};
                checks++;
                if (strobes !== exp_str) begin
                    errors++;
                    $display("FAIL decode k=%0d: got %b want %b",
                             k, strobes, exp_str);
                end
                if (k == 16 || k == 224) begin
                    checks++;
                    if (lfsr_out !== ((k == 16) ? 6'b111100 : 6'b010100)) begin
                        errors++;
                        $display("FAIL lfsr_state k=%0d: got %b", k, lfsr_out);
                    end
                end
            end
        end
        distinct = 0;
        for (int i = 0; i < 64; i++) distinct += int'(seen[i]);
        checks++;
        if (distinct != 57) begin
            errors++;
            $display("FAIL distinct: got %0d want 57", distinct);
        end
        checks++;
        if (rises != 4) begin
            errors++;
            $display("FAIL rises: got %0d want 4", rises);
        end
    endtask

    task automatic test_rsyn_pulse();
        wait_rise();
        repeat (81) tick();
        rsyn = 1'b1;
        tick();
        rsyn = 1'b0;
        checks++;
        if ({hphi1, hphi2, rsynl} !== 3'b101) begin
            errors++;
            $display("FAIL pulse_force: h1,h2,rsynl=%b want 101",
                     {hphi1, hphi2, rsynl});
        end
        tick();
        checks++;
        if ({rsynl, rsynd} !== 2'b11) begin
            errors++;
            $display("FAIL pulse_rsynd: rsynl,rsynd=%b want 11", {rsynl, rsynd});
        end
        tick();
        checks++;
        if ({hphi2, lfsr_out} !== {1'b1, 6'b110101}) begin
            errors++;
            $display("FAIL pulse_hold: h2=%b lfsr=%b want 1 110101",
                     hphi2, lfsr_out);
        end
        tick();
        checks++;
        if ({lfsr_out, shb, rsynl} !== 8'b000000_1_0) begin
            errors++;
            $display("FAIL pulse_reload: lfsr=%b shb=%b rsynl=%b want 000000 1 0",
                     lfsr_out, shb, rsynl);
        end
        tick();
        checks++;
        if (rsynd !== 1'b1) begin
            errors++;
            $display("FAIL rsynd_hold: got %b want 1", rsynd);
        end
        tick();
        checks++;
        if (rsynd !== 1'b0) begin
            errors++;
            $display("FAIL rsynd_clear: got %b want 0", rsynd);
        end
        repeat (13) tick();
        checks++;
        if (shs !== 1'b0) begin
            errors++;
            $display("FAIL shs_early: got %b want 0", shs);
        end
        tick();
        checks++;
        if (shs !== 1'b1) begin
            errors++;
            $display("FAIL shs_after_rsyn: got %b want 1", shs);
        end
    endtask

    task automatic test_rsyn_hold();
        logic [5:0] s;
        wait_rise();
        repeat (40) tick();
        s = lfsr_out;
        rsyn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({hphi1, hphi2, rsynl, lfsr_out} !== {3'b101, s}) begin
                errors++;
                $display("FAIL hold_%0d: h1,h2,rsynl=%b lfsr=%b want 101 %b",
                         i, {hphi1, hphi2, rsynl}, lfsr_out, s);
            end
        end
        rsyn = 1'b0;
        tick();
        tick();
        checks++;
        if ({hphi2, lfsr_out} !== {1'b1, s}) begin
            errors++;
            $display("FAIL hold_release: h2=%b lfsr=%b want 1 %b",
                     hphi2, lfsr_out, s);
        end
        tick();
        checks++;
        if ({lfsr_out, shb, rsynl} !== 8'b000000_1_0) begin
            errors++;
            $display("FAIL hold_reload: lfsr=%b shb=%b rsynl=%b want 000000 1 0",
                     lfsr_out, shb, rsynl);
        end
    endtask

    task automatic test_rsyn_end();
        int   r1;
        int   r2;
        int   early;
        logic prev;
        wait_rise();
        repeat (227) tick();
        rsyn = 1'b1;
        tick();
        rsyn = 1'b0;
        checks++;
        if ({lfsr_out, shb, rsynl, hphi1} !== 9'b000000_1_0_1) begin
            errors++;
            $display("FAIL end_rsyn: lfsr=%b shb=%b rsynl=%b h1=%b want 000000 1 0 1",
                     lfsr_out, shb, rsynl, hphi1);
        end
        r1 = -1;
        r2 = -1;
        early = 0;
        prev = shb;
        for (int i = 1; i <= 470; i++) begin
            tick();
            if (shb && !prev) begin
                if (i <= 200) early++;
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            prev = shb;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL end_single_shb: extra rises=%0d want 0", early);
        end
        checks++;
        if (r1 < 0 || r2 < 0 || r2 - r1 != 228) begin
            errors++;
            $display("FAIL end_next_line: rises at %0d,%0d want 228 apart", r1, r2);
        end
    endtask

    task automatic test_async_reset();
        int   k;
        bit   got;
        logic prev;
        wait_rise();
        repeat (50) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", all_out);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        check_phases(8);
        k = 8;
        got = 0;
        prev = shb;
        while (k < 300 && !got) begin
            tick();
            k++;
            if (shb && !prev) got = 1;
            prev = shb;
        end
        checks++;
        if (!got || k != 227) begin
            errors++;
            $display("FAIL restart_first_shb: got edge %0d want 227", k);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rsyn  = 1'b0;
        test_reset();
        test_free_run();
        test_rsyn_pulse();
        test_rsyn_hold();
        test_rsyn_end();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
